// File: rtl/audio_i2s_ctrl.sv
// audio_i2s_ctrl: I2S output controller with fractional MCLK/SCLK/LRCK generation and a one-entry sample buffer.
// Optional underrun counter enabled by defining AUDIO_I2S_UNDERRUN_COUNT_EN.
module audio_i2s_ctrl #(
   parameter int ACCUM_INC = 245760,
   parameter int ACCUM_MOD = 742500,
   parameter int ACCUM_W   = 22
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_left,
   input  logic [15:0] s_right,
   output logic        audio_mclk,
   output logic        audio_sclk,
   output logic        audio_lrck,
   output logic        audio_dac,
   output logic        frame_tick,
   output logic        underrun,
   output logic [15:0] underrun_count
);
   logic [ACCUM_W-1:0] r_acc;
   logic               r_mclk;
   logic [1:0]         r_div;
   logic [5:0]         r_bit;
   logic               r_lrck;
   logic               r_dac;
   logic [31:0]        r_frame;
   logic [31:0]        r_buf;
   logic               r_full;
   logic               r_ready;
   logic               r_tick;
   logic               r_und;

   logic               w_run;
   logic               w_wrap;
   logic               w_rise;
   logic               w_sfall;
   logic               w_start;
   logic               w_push;
   logic               w_pop;
   logic               w_full_nxt;
   logic [5:0]         w_s;
   logic [4:0]         w_idx;
   logic               w_bit;

   assign w_run      = reset_n & enable;
   assign w_wrap     = enable & (r_acc >= ACCUM_W'(ACCUM_MOD));
   assign w_rise     = w_wrap & ~r_mclk;
   assign w_sfall    = w_rise & (r_div == 2'd3);
   assign w_start    = w_sfall & (r_bit == 6'd63);
   assign w_push     = s_valid & r_ready;
   assign w_pop      = w_start & r_full;
   assign w_full_nxt = w_pop ? 1'b0 : w_push ? 1'b1 : r_full;
   assign w_s        = r_bit + 6'd1;
   // frame register holds {L,R}; slots 1..16 walk L MSB-first, slots 33..48 walk R
   assign w_idx      = (w_s <= 6'd16) ? 5'(6'd32 - w_s) : 5'(6'd48 - w_s);
   assign w_bit      = (((w_s >= 6'd1) && (w_s <= 6'd16)) || ((w_s >= 6'd33) && (w_s <= 6'd48))) & r_frame[w_idx];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_full  <= 1'b0;
         r_ready <= 1'b0;
         r_buf   <= '0;
      end else begin
         r_full  <= w_full_nxt;
         r_ready <= ~w_full_nxt;
         if (w_push) r_buf <= {s_left, s_right};
      end
   end

   always_ff @(posedge clk) begin
      if (!w_run) begin
         r_acc   <= '0;
         r_mclk  <= 1'b0;
         r_div   <= 2'd0;
         r_bit   <= 6'd0;
         r_lrck  <= 1'b0;
         r_dac   <= 1'b0;
         r_frame <= '0;
         r_tick  <= 1'b0;
         r_und   <= 1'b0;
      end else begin
         r_acc  <= w_wrap ? r_acc - ACCUM_W'(ACCUM_MOD) + ACCUM_W'(ACCUM_INC) : r_acc + ACCUM_W'(ACCUM_INC);
         r_tick <= w_start;
         r_und  <= w_start & ~r_full;
         if (w_wrap) r_mclk <= ~r_mclk;
         if (w_rise) r_div <= r_div + 2'd1;
         if (w_sfall) begin
            r_bit  <= w_s;
            r_dac  <= w_bit;
            r_lrck <= (r_bit == 6'd31) ? 1'b1 : (r_bit == 6'd63) ? 1'b0 : r_lrck;
         end
         if (w_start) r_frame <= r_full ? r_buf : 32'd0;
      end
   end

`ifdef AUDIO_I2S_UNDERRUN_COUNT_EN
   logic [15:0] r_ucnt;
   always_ff @(posedge clk) begin
      if (!reset_n) r_ucnt <= 16'd0;
      else if (w_start & ~r_full & (r_ucnt != 16'hFFFF)) r_ucnt <= r_ucnt + 16'd1;
   end
   assign underrun_count = r_ucnt;
`else
   assign underrun_count = 16'd0;
`endif

   assign s_ready    = r_ready;
   assign audio_mclk = r_mclk;
   assign audio_sclk = r_div[1];
   assign audio_lrck = r_lrck;
   assign audio_dac  = r_dac;
   assign frame_tick = r_tick;
   assign underrun   = r_und;
endmodule
